// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_sequencer
// Description : Queued command sequencer for a bank of WIDTH JK cells.
//               Each command (hold/set/clear/toggle with a per-bit mask)
//               drives J/K for SETTLE cycles, then idles J/K for one release
//               cycle, then compares the bank readback against a shadow copy
//               of the expected state.
// Ports       : clk        - clock, rising edge
//               R          - async active-high reset (shared with the bank)
//               cmd_valid  - command offered
//               cmd_ready  - queue can accept a command
//               cmd_op     - 00 hold, 01 set, 10 clear, 11 toggle
//               cmd_mask   - cells affected by the command
//               J, K       - drive lines to the bank
//               q_in       - Q readback from the bank
//               shadow     - expected bank state after last completed command
//               busy       - FSM not idle or queue not empty
//               done       - one-cycle completion pulse
//               err        - one-cycle readback mismatch pulse (with done)
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_sequencer #(
  parameter int WIDTH      = 4,
  parameter int SETTLE     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             R,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] shadow,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] C_SETTLE_INIT = CW'(SETTLE - 1);

  localparam logic [1:0] C_OP_HOLD   = 2'b00;
  localparam logic [1:0] C_OP_SET    = 2'b01;
  localparam logic [1:0] C_OP_CLEAR  = 2'b10;
  localparam logic [1:0] C_OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_RELEASE = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH+1:0] mem_q [FIFO_DEPTH];

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_mask;

  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // cmd_ready comes from registered pointers only, so a pop never reopens
  // a full queue within the same cycle.
  assign push = cmd_valid && !full;
  assign pop  = (state_q == S_IDLE) && !empty;

  assign {head_op, head_mask} = mem_q[rd_ptr_q[AW-1:0]];

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_mask};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    expected_d = expected_q;
    j_d        = j_q;
    k_d        = k_q;
    shadow_d   = shadow_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};

    case (state_q)
      S_IDLE: begin
        j_d = '0;
        k_d = '0;
        if (pop) begin
          cnt_d   = C_SETTLE_INIT;
          state_d = S_DRIVE;
          case (head_op)
            C_OP_SET: begin
              expected_d = shadow_q | head_mask;
              j_d        = head_mask;
            end
            C_OP_CLEAR: begin
              expected_d = shadow_q & ~head_mask;
              k_d        = head_mask;
            end
            C_OP_TOGGLE: begin
              expected_d = shadow_q ^ head_mask;
              j_d        = head_mask;
              k_d        = head_mask;
            end
            default: begin
              expected_d = shadow_q;
            end
          endcase
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          j_d     = '0;
          k_d     = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RELEASE: begin
        // J=K=0 for a full cycle before sampling so a level-sensitive
        // toggle in the bank has settled.
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // Shadow tracks the commanded value even on a mismatch.
        shadow_d = expected_q;
        done_d   = 1'b1;
        err_d    = (q_in != expected_q);
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        j_d     = '0;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      expected_q <= '0;
      j_q        <= '0;
      k_q        <= '0;
      shadow_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      expected_q <= expected_d;
      j_q        <= j_d;
      k_q        <= k_d;
      shadow_q   <= shadow_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign J         = j_q;
  assign K         = k_q;
  assign shadow    = shadow_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cmd_ready = !full;
  assign busy      = (state_q != S_IDLE) || !empty;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_sequencer
// Description : Self-checking bench for jk_bank_sequencer with a behavioural
//               JK bank model, a vector table and a completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_sequencer;

  localparam int WIDTH      = 4;
  localparam int SETTLE     = 3;
  localparam int FIFO_DEPTH = 4;

  logic             clk = 1'b0;
  logic             R;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [WIDTH-1:0] J, K, q_in, shadow;
  logic             busy, done, err;

  logic             tie_zero;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] jk_prev;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int done_times[$];

  typedef struct {
    logic [WIDTH-1:0] shadow;
    logic             err;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] mask;
    logic             tie;
    logic [WIDTH-1:0] exp_j;
    logic [WIDTH-1:0] exp_k;
    logic [WIDTH-1:0] exp_shadow;
    logic             exp_err;
  } vec_t;
  vec_t tbl[7];

  jk_bank_sequencer #(
    .WIDTH(WIDTH), .SETTLE(SETTLE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .R(R), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .J(J), .K(K), .q_in(q_in),
    .shadow(shadow), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // JK bank model: set/clear are level actions, toggle fires once per
  // assertion of J&K; shares the reset net with the sequencer.
  always @(posedge clk or posedge R) begin
    if (R) begin
      bank_q  <= '0;
      jk_prev <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (J[b] && !K[b])                 bank_q[b] <= 1'b1;
        else if (!J[b] && K[b])            bank_q[b] <= 1'b0;
        else if (J[b] && K[b] && !jk_prev[b]) bank_q[b] <= ~bank_q[b];
      end
      jk_prev <= J & K;
    end
  end

  assign q_in = tie_zero ? '0 : bank_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_next(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] m,
                                                  input logic [WIDTH-1:0] s);
    case (op)
      2'b01:   return s | m;
      2'b10:   return s & ~m;
      2'b11:   return s ^ m;
      default: return s;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: every done pops the scoreboard.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      done_times.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_e = sb.pop_front();
        chk("sb_shadow", shadow, sb_e.shadow);
        chk("sb_err", err, sb_e.err);
      end
    end
  end

  logic [1:0]       bp_op   [6];
  logic [WIDTH-1:0] bp_mask [6];
  logic [WIDTH-1:0] ms;
  logic             acc;
  int               accepted;
  logic             saw_full;

  initial begin
    tbl[0] = '{2'b01, 4'b0101, 1'b0, 4'b0101, 4'b0000, 4'b0101, 1'b0};
    tbl[1] = '{2'b11, 4'b0011, 1'b0, 4'b0011, 4'b0011, 4'b0110, 1'b0};
    tbl[2] = '{2'b10, 4'b0100, 1'b0, 4'b0000, 4'b0100, 4'b0010, 1'b0};
    tbl[3] = '{2'b00, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0};
    tbl[4] = '{2'b01, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0};
    tbl[5] = '{2'b01, 4'b1111, 1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b1};
    tbl[6] = '{2'b11, 4'b1010, 1'b0, 4'b1010, 4'b1010, 4'b0101, 1'b0};

    bp_op[0] = 2'b01; bp_mask[0] = 4'b0001;
    bp_op[1] = 2'b11; bp_mask[1] = 4'b0110;
    bp_op[2] = 2'b10; bp_mask[2] = 4'b0010;
    bp_op[3] = 2'b11; bp_mask[3] = 4'b1111;
    bp_op[4] = 2'b00; bp_mask[4] = 4'b0000;
    bp_op[5] = 2'b01; bp_mask[5] = 4'b1000;

    R = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_mask = '0; tie_zero = 1'b0;

    // Reset then idle
    tick(); tick();
    R = 1'b0;
    chk("rst_j", J, 4'b0000);
    chk("rst_k", K, 4'b0000);
    chk("rst_shadow", shadow, 4'b0000);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    done_cnt = 0;
    repeat (20) tick();
    chk("idle_no_done", done_cnt, 0);

    // Table-driven single commands, each from an empty idle sequencer
    for (int i = 0; i < 7; i++) begin
      tie_zero  = tbl[i].tie;
      cmd_valid = 1'b1;
      cmd_op    = tbl[i].op;
      cmd_mask  = tbl[i].mask;
      chk("v_ready", cmd_ready, 1'b1);
      tick();                                   // push edge
      cmd_valid = 1'b0;
      sb.push_back('{tbl[i].exp_shadow, tbl[i].exp_err});
      chk("v_busy_queued", busy, 1'b1);
      chk("v_j_prepop", J, 4'b0000);
      for (int c = 0; c < SETTLE; c++) begin    // pop edge E0 .. E0+SETTLE-1
        tick();
        chk("v_drive_j", J, tbl[i].exp_j);
        chk("v_drive_k", K, tbl[i].exp_k);
      end
      tick();                                   // E0+SETTLE: release
      chk("v_rel_j", J, 4'b0000);
      chk("v_rel_k", K, 4'b0000);
      tick();                                   // E0+SETTLE+1: check state
      chk("v_early_done", done, 1'b0);
      tick();                                   // E0+SETTLE+2: done
      chk("v_done", done, 1'b1);
      chk("v_err", err, tbl[i].exp_err);
      tick();
      chk("v_done_pulse", done, 1'b0);
      chk("v_idle", busy, 1'b0);
      tie_zero = 1'b0;
    end
    ms = tbl[6].exp_shadow;

    // Backpressure: six back-to-back pushes into a four-entry queue
    done_times.delete();
    accepted  = 0;
    saw_full  = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = bp_op[0];
    cmd_mask  = bp_mask[0];
    for (int t = 0; t < 200 && accepted < 6; t++) begin
      acc = cmd_ready;
      if (!cmd_ready) saw_full = 1'b1;
      tick();
      if (acc) begin
        ms = model_next(bp_op[accepted], bp_mask[accepted], ms);
        sb.push_back('{ms, 1'b0});
        accepted++;
        if (accepted < 6) begin
          cmd_op   = bp_op[accepted];
          cmd_mask = bp_mask[accepted];
        end
      end
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", accepted, 6);
    chk("bp_ready_dropped", saw_full, 1'b1);
    for (int t = 0; t < 100 && (sb.size() != 0 || busy); t++) tick();
    chk("bp_drained", sb.size(), 0);
    chk("bp_done_count", done_times.size(), 6);
    for (int i = 1; i < done_times.size(); i++)
      chk("bp_done_gap", done_times[i] - done_times[i-1], SETTLE + 3);
    chk("bp_final_shadow", shadow, ms);

    // Mid-operation reset with two commands still queued
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_mask = 4'b1111;
    tick();                                     // push 1
    tick();                                     // pop 1, push 2
    tick();                                     // push 3, driving
    cmd_valid = 1'b0;
    chk("mr_driving", J, 4'b1111);
    #2;
    R = 1'b1;
    #1;                                         // well before next edge
    chk("mr_j_async", J, 4'b0000);
    chk("mr_k_async", K, 4'b0000);
    chk("mr_shadow", shadow, 4'b0000);
    chk("mr_busy", busy, 1'b0);
    chk("mr_ready", cmd_ready, 1'b1);
    sb.delete();
    done_cnt = 0;
    tick();
    R = 1'b0;
    repeat (15) tick();
    chk("mr_no_done", done_cnt, 0);
    chk("mr_shadow_after", shadow, 4'b0000);
    chk("mr_idle_after", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
